// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared SRAM geometry, base address and controller states
package arm_mem_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
  localparam int          SRAM_DW           = 16;
  localparam int          SRAM_AW           = 18;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } mem_state_t;

  // Half-word SRAM address of a 32-bit word: word index from the byte offset, plus the half select.
  function automatic logic [SRAM_AW-1:0] sram_half_addr(input logic [16:0] word_idx,
                                                        input logic        upper);
    return {word_idx, upper};
  endfunction

endpackage

// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - MEM-stage sequencer splitting 32-bit accesses into two 16-bit SRAM phases
module sram_mem_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  mem_state_t  state;
  logic [3:0]  cnt;
  logic        is_write;

  logic        req;
  logic        phase_end;
  logic        in_phase;
  logic [31:0] off;
  logic        unused_off_bits;

  assign req       = wr_en | rd_en;
  assign phase_end = (cnt == LAST_CNT);
  assign in_phase  = (state == LOW) || (state == HIGH);
  assign off       = address - BASE_ADDR;
  assign unused_off_bits = ^{off[31:19], off[1:0]};

  // Access type is captured on entry to LOW; a simultaneous read and write is a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      is_write  <= 1'b0;
      read_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state    <= LOW;
            cnt      <= 4'd0;
            is_write <= wr_en;
          end
        end
        LOW: begin
          if (phase_end) begin
            state <= HIGH;
            cnt   <= 4'd0;
            if (!is_write) read_data[15:0] <= sram_dq;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            state <= DONE;
            cnt   <= 4'd0;
            if (!is_write) read_data[31:16] <= sram_dq;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          // Any request still present belongs to the instruction just finished.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = ((state == IDLE) && !req) || (state == DONE);

  assign sram_addr = sram_half_addr(off[18:2], state == HIGH);

  // Strobe released on the final cycle of each phase so data is held across the rising edge.
  assign sram_we_n = !(in_phase && is_write && !phase_end);

  assign sram_dq = (in_phase && is_write)
                 ? ((state == HIGH) ? write_data[31:16] : write_data[15:0])
                 : {SRAM_DW{1'bz}};

  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb/tb_sram_mem_controller.sv - self-checking bench for sram_mem_controller with behavioural SRAMs
module tb_sram_mem_controller;

  localparam int W4 = 4;
  localparam int W2 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr4, rd4, wr2, rd2;
  logic [31:0] addr4, wd4, addr2, wd2;
  logic [31:0] rdata4, rdata2;
  logic        ready4, ready2;
  wire  [15:0] dq4, dq2;
  logic [17:0] sa4, sa2;
  logic        we4, we2;
  logic        ub4, lb4, ce4, oe4, ub2, lb2, ce2, oe2;
  logic        drv4, drv2;

  logic [15:0] mem4 [0:262143];
  logic [15:0] mem2 [0:262143];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] ref_mem [int unsigned];
  logic [31:0] ref_rd;

  always #5 clk = ~clk;

  sram_mem_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W4)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr4), .rd_en(rd4), .address(addr4), .write_data(wd4),
    .read_data(rdata4), .ready(ready4), .sram_dq(dq4), .sram_addr(sa4), .sram_we_n(we4),
    .sram_ub_n(ub4), .sram_lb_n(lb4), .sram_ce_n(ce4), .sram_oe_n(oe4));

  sram_mem_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(rd2), .address(addr2), .write_data(wd2),
    .read_data(rdata2), .ready(ready2), .sram_dq(dq2), .sram_addr(sa2), .sram_we_n(we2),
    .sram_ub_n(ub2), .sram_lb_n(lb2), .sram_ce_n(ce2), .sram_oe_n(oe2));

  // Asynchronous SRAMs: combinational read while the bench owns the bus, write on we_n rising.
  pullup pu4 (dq4);
  pullup pu2 (dq2);
  assign dq4 = (drv4 && !oe4) ? mem4[sa4] : 16'hzzzz;
  assign dq2 = (drv2 && !oe2) ? mem2[sa2] : 16'hzzzz;
  always @(posedge we4) if (!rst) mem4[sa4] <= dq4;
  always @(posedge we2) if (!rst) mem2[sa2] <= dq2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned hw_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return ((off / 32'd4) % 32'd131072) * 32'd2;
  endfunction

  function automatic logic [15:0] ref_get(input int unsigned k);
    return ref_mem.exists(k) ? ref_mem[k] : 16'h0000;
  endfunction

  // Present one request at a negedge; returns the 1-based cycle in which ready is first high.
  task automatic run_op(input int sel, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] wd, output int lat);
    @(negedge clk);
    if (sel == W4) begin
      wr4 = wr; rd4 = rd; addr4 = a; wd4 = wd; drv4 = rd && !wr;
    end else begin
      wr2 = wr; rd2 = rd; addr2 = a; wd2 = wd; drv2 = rd && !wr;
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if ((sel == W4) ? ready4 : ready2) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic op4(input logic wr, input logic rd, input logic [31:0] a,
                     input logic [31:0] wd, input string tag);
    int          lat;
    int          exp_lat;
    int unsigned k;
    k       = hw_of(a);
    exp_lat = (wr || rd) ? 2 * W4 + 2 : 1;
    if (wr) begin
      ref_mem[k]     = wd[15:0];
      ref_mem[k + 1] = wd[31:16];
    end else if (rd) begin
      ref_rd = {ref_get(k + 1), ref_get(k)};
    end
    run_op(W4, wr, rd, a, wd, lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " read_data"}, rdata4, ref_rd);
    if (wr) begin
      check({tag, " sram lo"}, {16'h0, mem4[k]}, {16'h0, wd[15:0]});
      check({tag, " sram hi"}, {16'h0, mem4[k + 1]}, {16'h0, wd[31:16]});
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        chk;
    int unsigned hw;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          lat;
    int unsigned k;
    logic        r_wr, r_rd;
    logic [31:0] r_a, r_wd;

    for (int i = 0; i < 262144; i++) begin
      mem4[i] = 16'h0000;
      mem2[i] = 16'h0000;
    end
    rst = 1'b1;
    wr4 = 0; rd4 = 0; addr4 = 32'd1024; wd4 = 32'h00C3_1234; drv4 = 0;
    wr2 = 0; rd2 = 0; addr2 = 32'd1024; wd2 = 32'h00C3_1234; drv2 = 0;
    ref_rd = 32'd0;

    vecs[0] = '{1'b1, 1'b0, 32'd1032,           32'hDEADBEEF, 32'h00000000, 1'b1, 4,       16'hBEEF, 16'hDEAD};
    vecs[1] = '{1'b0, 1'b1, 32'd1032,           32'h0,        32'hDEADBEEF, 1'b1, 4,       16'hBEEF, 16'hDEAD};
    vecs[2] = '{1'b1, 1'b1, 32'd1024,           32'h12345678, 32'hDEADBEEF, 1'b1, 0,       16'h5678, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 32'd1024,           32'h0,        32'h12345678, 1'b0, 0,       16'h0,    16'h0};
    vecs[4] = '{1'b1, 1'b0, 32'd0,              32'hCAFEF00D, 32'h12345678, 1'b1, 'h3FE00, 16'hF00D, 16'hCAFE};
    vecs[5] = '{1'b0, 1'b1, 32'd0,              32'h0,        32'hCAFEF00D, 1'b0, 0,       16'h0,    16'h0};
    vecs[6] = '{1'b0, 1'b1, 32'd1024 + 'h80000, 32'h0,        32'h12345678, 1'b0, 0,       16'h0,    16'h0};
    vecs[7] = '{1'b0, 1'b0, 32'd1028,           32'h0,        32'h12345678, 1'b0, 0,       16'h0,    16'h0};

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("idle ready", ready4, 1'b1);
      check("idle we_n", we4, 1'b1);
      check("idle dq released", dq4, 16'hFFFF);
      check("idle read_data", rdata4, 32'd0);
    end
    check("idle ready w2", ready2, 1'b1);
    check("tied enables", {ub4, lb4, ce4, oe4, ub2, lb2, ce2, oe2}, 8'h00);

    for (int i = 0; i < 8; i++) begin
      op4(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].wd, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table read_data", i), rdata4, vecs[i].exp_rd);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d table lo", i), {16'h0, mem4[vecs[i].hw]}, {16'h0, vecs[i].exp_lo});
        check($sformatf("vec%0d table hi", i), {16'h0, mem4[vecs[i].hw + 1]}, {16'h0, vecs[i].exp_hi});
      end
    end

    for (int i = 0; i < 30; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_rd = 1'($urandom_range(0, 1));
      r_wd = $urandom;
      if ($urandom_range(0, 3) != 0) r_a = 32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      else                           r_a = $urandom;
      op4(r_wr, r_rd, r_a, r_wd, $sformatf("rand%0d", i));
    end

    // Reset during the third HIGH cycle of a store.
    k = hw_of(32'd1040);
    mem4[k + 1] = 16'h5A5A;
    @(negedge clk);
    wr4 = 1; rd4 = 0; addr4 = 32'd1040; wd4 = 32'h87654321; drv4 = 0;
    for (int i = 1; i < 8; i++) @(negedge clk);
    #1;
    check("mid HIGH we_n", we4, 1'b0);
    check("mid HIGH addr", {14'd0, sa4}, k + 1);
    rst = 1'b1;
    wr4 = 0;
    #1;
    check("reset ready", ready4, 1'b1);
    check("reset we_n", we4, 1'b1);
    check("reset dq released", dq4, 16'hFFFF);
    check("reset read_data", rdata4, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post reset ready", ready4, 1'b1);
    check("reset lo written", {16'h0, mem4[k]}, 32'h4321);
    check("reset hi untouched", {16'h0, mem4[k + 1]}, 32'h5A5A);

    mem2[0] = 16'h1111; mem2[1] = 16'h2222; mem2[2] = 16'h3333; mem2[3] = 16'h4444;
    run_op(W2, 1'b0, 1'b1, 32'd1024, 32'h0, lat);
    check("w2 load0 latency", lat, 2 * W2 + 2);
    check("w2 load0 data", rdata2, 32'h22221111);
    run_op(W2, 1'b0, 1'b1, 32'd1028, 32'h0, lat);
    check("w2 load1 latency", lat, 2 * W2 + 2);
    check("w2 load1 data", rdata2, 32'h44443333);
    run_op(W2, 1'b1, 1'b0, 32'd1036, 32'hA1B2C3D4, lat);
    check("w2 store latency", lat, 2 * W2 + 2);
    check("w2 store lo", {16'h0, mem2[6]}, 32'hC3D4);
    check("w2 store hi", {16'h0, mem2[7]}, 32'hA1B2);
    check("w2 store keeps read_data", rdata2, 32'h44443333);
    run_op(W2, 1'b0, 1'b0, 32'd1024, 32'h0, lat);
    check("w2 no request", lat, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Multi-cycle controller that sequences the off-chip 16-bit SRAM for the MEM stage of the ARM pipeline. It takes the MEM-stage read/write enables, ALU-computed address and store data, splits each 32-bit access into two half-word SRAM phases, and drives `ready` low to freeze the pipeline until the access completes. Sits between the EXE/MEM pipeline register outputs and the MEM/WB register inputs.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0; subtracted from `address`.
- `WAIT_CYCLES`, 4: cycles spent in each half-word phase; legal range 2..15.
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: store request (MEM stage `mem_write_en`).
- `rd_en` in 1: load request (MEM stage `mem_read_en`).
- `address` in 32: byte address (MEM stage ALU result).
- `write_data` in 32: store data (MEM stage Rm value).
- `read_data` out 32: last completed load word.
- `ready` out 1: 1 = pipeline may advance; 0 = freeze all pipeline registers and PC.
- `sram_dq` inout 16: SRAM data bus.
- `sram_addr` out 18: SRAM half-word address.
- `sram_we_n` out 1: SRAM write strobe, active low.
- `sram_ub_n`, `sram_lb_n`, `sram_ce_n`, `sram_oe_n` out 1 each: tied 0 (always enabled).

## Operation
- States: IDLE, LOW, HIGH, DONE. 4-bit phase counter `cnt`.
- IDLE: if `wr_en|rd_en` → LOW, `cnt`←0; else stay.
- LOW: `cnt` increments; at `cnt==WAIT_CYCLES-1` → HIGH, `cnt`←0.
- HIGH: same counting; at `cnt==WAIT_CYCLES-1` → DONE.
- DONE: unconditionally → IDLE (request seen in DONE belongs to the completed instruction; it is not restarted).
- `ready` combinational: 1 in IDLE with no request, 1 in DONE, 0 otherwise.
- Address: `off = address - BASE_ADDR` (32-bit, wraps modulo 2^32); LOW: `sram_addr = {off[18:2],1'b0}`; HIGH: `{off[18:2],1'b1}`; IDLE/DONE: `{off[18:2],1'b0}`. `off[1:0]` ignored.
- Write: `sram_dq` driven with `write_data[15:0]` in LOW, `write_data[31:16]` in HIGH; high-Z in all other states and for reads. `sram_we_n`=0 while `cnt<WAIT_CYCLES-1` in LOW/HIGH of a write; 1 on the last cycle of each phase (data hold) and everywhere else.
- Read: `read_data[15:0]` ← `sram_dq` on the clock edge ending the last LOW cycle; `read_data[31:16]` ← `sram_dq` on the edge ending the last HIGH cycle. `read_data` otherwise holds.
- `wr_en` and `rd_en` both 1: treated as write; `read_data` unchanged.
- Access type latched at IDLE→LOW; input changes during LOW/HIGH are ignored for type (pipeline is frozen, inputs stable by contract).

## Timing
- Request first visible in cycle c (IDLE): `ready`=0 in c. LOW occupies c+1..c+W, HIGH c+W+1..c+2W, DONE c+2W+1 with `ready`=1; pipeline advances on the edge ending c+2W+1. Default W=4: 10 cycles, `ready` high in the 10th.
- `read_data` valid from DONE cycle onward.
- Back-to-back requests: next request's IDLE cycle is c+2W+2; no gap-free chaining.
- No request: zero-latency, `ready`=1 continuously.
- Reset (any time, including mid-access): state IDLE, `cnt`=0, `read_data`=0, `sram_we_n`=1, `sram_dq` high-Z, `sram_addr`=0-derived from inputs, `ready` per IDLE rule. Interrupted write may leave SRAM partially written; no recovery.

## Structure
- Shared package `arm_mem_pkg`: `BASE_ADDR` default, SRAM data/address widths (16/18), state enum (IDLE, LOW, HIGH, DONE).
- Single module; no RTL sub-module. Bench uses a behavioural `sram_model` (256K×16, asynchronous, we_n-edge write).

## Test plan
- Reset then idle, no enables → `ready`=1 every cycle, `sram_we_n`=1, `sram_dq` high-Z, `read_data`=0.
- Store `address`=1024+8, `write_data`=0xDEADBEEF → SRAM half-word 4 = 0xBEEF, 5 = 0xDEAD; `ready`=0 for 9 cycles then 1 for one cycle.
- Load same address after store → `read_data`=0xDEADBEEF in DONE cycle, 10 cycles after request.
- `wr_en`=`rd_en`=1, `write_data`=0x12345678 at 1024 → SRAM written, `read_data` keeps previous value.
- Assert `rst` in the 3rd HIGH cycle of a store → next cycle IDLE, `sram_we_n`=1, `ready`=1 with no request, high half of SRAM untouched.
- WAIT_CYCLES=2 load → `ready` high in 6th cycle; back-to-back loads to 1024, 1028 each take 6 cycles with one IDLE cycle between.
